// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    FINISH,
    ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 2;

endpackage

// File: rtl/imem_word_serializer.sv
// Holds one accepted instruction word and hands it out one byte per cycle,
// lowest-address byte first, flagging the final byte of the word.
module imem_word_serializer
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [31:0]      word_in,
  input  logic             advance,
  output logic [7:0]       byte_out,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [31:0] word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      idx    <= '0;
    end else if (load) begin
      word_q <= word_in;
      idx    <= '0;
    end else if (advance) begin
      idx <= idx + 1'b1;
    end
  end

  always_comb begin
    byte_out = word_q[7:0];
    case (idx)
      2'd0:    byte_out = word_q[7:0];
      2'd1:    byte_out = word_q[15:8];
      2'd2:    byte_out = word_q[23:16];
      default: byte_out = word_q[31:24];
    endcase
  end

  assign last = (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into byte-addressed instruction memory while
// holding the CPU in reset. Optional checksum check: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  input  logic [31:0]       expected_sum,
  output logic              sum_ok
`endif
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, hold_addr, live_addr;
  logic [7:0]        hold_data, ser_byte;
  logic [CNT_W-1:0]  remaining;
  logic              err_q, start_bad, handshake, ser_last, sum_bad;
  logic [IDX_W-1:0]  ser_idx;
  logic [ADDR_W+1:0] end_addr;

  // Range check is done two bits wider than the address so it cannot wrap.
  assign end_addr  = {2'b00, base_addr} + ((ADDR_W+2)'(word_count) << 2);
  assign start_bad = (base_addr[1:0] != 2'b00) || (end_addr > (ADDR_W+2)'(MEM_BYTES));
  assign handshake = (state == ACCEPT) && s_valid;
  assign live_addr = ptr + ADDR_W'(ser_idx);

  imem_word_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (handshake),
    .word_in  (s_data),
    .advance  (state == WRITE),
    .byte_out (ser_byte),
    .idx      (ser_idx),
    .last     (ser_last)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, exp_sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q     <= '0;
      exp_sum_q <= '0;
    end else if (state == IDLE && start) begin
      sum_q     <= '0;
      exp_sum_q <= expected_sum;
    end else if (handshake) begin
      sum_q <= sum_q + s_data;
    end
  end

  assign sum_bad = (sum_q != exp_sum_q);
  assign sum_ok  = !sum_bad;
`else
  assign sum_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Address/count bookkeeping; the hold registers keep the write bus quiet between bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
      err_q     <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        ptr       <= base_addr;
        remaining <= word_count;
        err_q     <= start_bad;
      end
      if (state == WRITE) begin
        hold_addr <= live_addr;
        hold_data <= ser_byte;
        if (ser_last) begin
          ptr       <= ptr + ADDR_W'(BYTES_PER_WORD);
          remaining <= remaining - 1'b1;
        end
      end
      if (state == FINISH && sum_bad) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    err        = err_q;
    mem_addr   = hold_addr;
    mem_wdata  = hold_data;
    case (state)
      IDLE: begin
        if (start) begin
          if (start_bad)             state_next = ERROR;
          else if (word_count == '0) state_next = FINISH;
          else                       state_next = ACCEPT;
        end
      end
      ACCEPT: begin
        s_ready  = 1'b1;
        cpu_hold = 1'b1;
        if (s_valid) state_next = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        cpu_hold  = 1'b1;
        mem_addr  = live_addr;
        mem_wdata = ser_byte;
        if (ser_last) state_next = (remaining == CNT_W'(1)) ? FINISH : ACCEPT;
      end
      FINISH: begin
        done       = 1'b1;
        err        = err_q | sum_bad;
        state_next = IDLE;
      end
      ERROR: begin
        done       = 1'b1;
        err        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized loads checked against a
// queue-based model of the expected byte writes and done timing.
module tb_imem_loader;

  localparam int MEM_BYTES = 128;

  logic        clk = 1'b0;
  logic        reset, start, s_valid, s_ready;
  logic [31:0] base_addr, s_data, mem_addr;
  logic [15:0] word_count;
  logic        mem_we, cpu_hold, busy, done, err;
  logic [7:0]  mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] expected_sum;
  logic        sum_ok;
`endif

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .expected_sum (expected_sum),
    .sum_ok       (sum_ok)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  int         exp_done_cyc = -1;
  int         checks = 0;
  int         errors = 0;
  int         wr_count = 0;
  logic [7:0] dut_mem [MEM_BYTES];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] sum_of(input logic [31:0] w[$]);
    logic [31:0] s = 0;
    foreach (w[i]) s += w[i];
    return s;
  endfunction

  // Every cycle: byte writes must match the expected queue exactly in time,
  // done must pulse only on the predicted cycle, and cpu_hold follows the state.
  always @(negedge clk) begin
    if (!reset) begin
      check_output("done_timing", done, (cyc == exp_done_cyc));
      check_output("hold_rule", cpu_hold, busy && !done);
      if (mem_we) check_output("ready_in_write", s_ready, 0);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check_output("missing_write_addr", 32'hFFFF_FFFF, exp_q[0].addr);
        void'(exp_q.pop_front());
      end
      if (mem_we) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          check_output("unexpected_write", mem_we, 0);
        end else begin
          check_output("write_addr", mem_addr, exp_q[0].addr);
          check_output("write_data", mem_wdata, exp_q[0].data);
          if (mem_addr < MEM_BYTES) dut_mem[mem_addr] = mem_wdata;
          wr_count++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One complete load: start pulse, word stream with gaps, then done/err checks.
  task automatic apply_stimulus(input logic [31:0] base, input logic [31:0] words[$],
                                input int gap_min, input int gap_max, input bit poke_start,
                                input int rst_byte, input logic [31:0] sum_exp,
                                output int hs_first, output int done_cyc);
    int   k0, gap, waited, hs_last, guard, n;
    bit   bad, got, exp_e;
    n        = words.size();
    bad      = (base[1:0] != 2'b00) || (longint'(base) + 4 * longint'(n) > MEM_BYTES);
    hs_first = -1;
    hs_last  = -1;
    done_cyc = -1;
    exp_e    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_e        = !bad && (sum_of(words) != sum_exp);
    expected_sum = sum_exp;
`endif
    start      = 1'b1;
    base_addr  = base;
    word_count = 16'(n);
    k0         = cyc;
    if (bad || n == 0) exp_done_cyc = k0 + 1;
    step();
    start      = 1'b0;
    base_addr  = $urandom;
    word_count = 16'($urandom);
    if (bad || n == 0) begin
      check_output("short_done", done, 1);
      check_output("short_err", err, bad | exp_e);
      check_output("short_ready", s_ready, 0);
      done_cyc = cyc;
      step();
      check_output("short_err_sticky", err, bad | exp_e);
      check_output("short_idle", busy, 0);
      return;
    end
    for (int w = 0; w < n; w++) begin
      gap    = $urandom_range(gap_max, gap_min);
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 40) begin
        if (gap > 0) begin
          s_valid = 1'b0;
          s_data  = $urandom;
          gap--;
        end else begin
          s_valid = 1'b1;
          s_data  = words[w];
        end
        if (s_valid && s_ready) begin
          got = 1'b1;
          if (w == 0) hs_first = cyc;
          hs_last = cyc;
          for (int i = 0; i < 4; i++)
            exp_q.push_back('{cyc + 1 + i, base + 32'(4 * w + i), words[w][8*i +: 8]});
          if (w == n - 1) exp_done_cyc = cyc + 5;
        end
        step();
        waited++;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("[TB] FAIL handshake_timeout: word %0d never accepted, s_ready=%0b expected 1", w, s_ready);
        s_valid = 1'b0;
        return;
      end
      s_data = $urandom;
      if (poke_start) begin
        start      = 1'b1;
        base_addr  = 32'h2;
        word_count = 16'd1;
        step();
        start = 1'b0;
      end
    end
    s_valid = 1'b0;
    if (rst_byte >= 0) begin
      while (cyc < hs_last + 1 + rst_byte) step();
      reset        = 1'b1;
      exp_done_cyc = -1;
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      step();
      check_output("rst_ready", s_ready, 0);
      check_output("rst_we", mem_we, 0);
      check_output("rst_addr", mem_addr, 0);
      check_output("rst_wdata", mem_wdata, 0);
      check_output("rst_hold", cpu_hold, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_err", err, 0);
      reset = 1'b0;
      step();
      return;
    end
    guard = 0;
    while (cyc < exp_done_cyc && guard < 20) begin
      step();
      guard++;
    end
    check_output("done_cycle", cyc, exp_done_cyc);
    check_output("end_done", done, 1);
    check_output("end_err", err, exp_e);
    check_output("end_hold", cpu_hold, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check_output("end_sum_ok", sum_ok, !exp_e);
`endif
    done_cyc = cyc;
    step();
    check_output("end_idle", busy, 0);
    check_output("end_err_sticky", err, exp_e);
    check_output("pending_writes", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] words[$];
    logic [7:0]  basic_exp [8];
    logic [31:0] base;
    int          hs, dc, wr0, n;

    basic_exp = '{8'h33, 8'h03, 8'h94, 8'h00, 8'hB3, 8'h00, 8'h01, 8'h80};
    foreach (dut_mem[i]) dut_mem[i] = 8'h00;
    reset      = 1'b1;
    start      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    base_addr  = '0;
    word_count = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    expected_sum = '0;
`endif
    repeat (3) step();
    check_output("reset_ready", s_ready, 0);
    check_output("reset_we", mem_we, 0);
    check_output("reset_addr", mem_addr, 0);
    check_output("reset_wdata", mem_wdata, 0);
    check_output("reset_hold", cpu_hold, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_err", err, 0);
    reset = 1'b0;
    step();

    $display("[TB] basic load");
    words = '{32'h0094_0333, 32'h8001_00B3};
    apply_stimulus(0, words, 0, 0, 0, -1, sum_of(words), hs, dc);
    check_output("basic_done_latency", dc - hs, 10);
    for (int i = 0; i < 8; i++) check_output($sformatf("basic_byte%0d", i), dut_mem[i], basic_exp[i]);

    $display("[TB] backpressure");
    wr0   = wr_count;
    words = '{$urandom, $urandom, $urandom};
    apply_stimulus(8, words, 7, 7, 0, -1, sum_of(words), hs, dc);
    check_output("bp_write_count", wr_count - wr0, 12);

    $display("[TB] boundaries");
    words = '{32'hDEAD_BEEF};
    apply_stimulus(124, words, 0, 1, 0, -1, sum_of(words), hs, dc);
    check_output("top_byte", dut_mem[127], 8'hDE);
    wr0   = wr_count;
    words = '{$urandom, $urandom};
    apply_stimulus(124, words, 0, 0, 0, -1, sum_of(words), hs, dc);
    words = '{$urandom};
    apply_stimulus(2, words, 0, 0, 0, -1, sum_of(words), hs, dc);
    words.delete();
    apply_stimulus(16, words, 0, 0, 0, -1, 0, hs, dc);
    check_output("no_write_on_short", wr_count - wr0, 0);

    $display("[TB] start during write");
    words = '{$urandom, $urandom};
    apply_stimulus(40, words, 0, 2, 1, -1, sum_of(words), hs, dc);

    $display("[TB] reset mid-load");
    words = '{$urandom, $urandom};
    apply_stimulus(0, words, 0, 0, 0, 2, sum_of(words), hs, dc);
    words = '{32'h1234_5678, 32'h9ABC_DEF0};
    apply_stimulus(0, words, 0, 0, 0, -1, sum_of(words), hs, dc);
    check_output("reload_byte4", dut_mem[4], 8'hF0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum");
    words = '{32'h1, 32'h2, 32'hFFFF_FFFF};
    apply_stimulus(64, words, 0, 0, 0, -1, 32'd2, hs, dc);
    apply_stimulus(64, words, 0, 0, 0, -1, 32'd3, hs, dc);
`endif

    $display("[TB] random loads");
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 9) == 0) base = $urandom_range(0, MEM_BYTES - 1);
      else                           base = 4 * $urandom_range(0, MEM_BYTES / 4 - 1);
      n = $urandom_range(0, 6);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      apply_stimulus(base, words, 0, 3, bit'($urandom_range(0, 1)), -1, sum_of(words), hs, dc);
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the processor's byte-addressed instruction memory.
- Accepts 32-bit instruction words on a valid/ready stream from the test harness or a host link.
- Serialises each word into four little-endian byte writes on the memory's byte write port.
- Holds the CPU in reset (cpu_hold) while a load runs, so a program can be loaded at run time instead of being hard-coded at reset.

Parameters:
MEM_BYTES, 128, instruction memory depth in bytes; the legal byte address range is 0..MEM_BYTES-1.
ADDR_W, 32, width of byte addresses; matches the PC width.
CNT_W, 16, width of word_count.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a load; sampled only in IDLE
base_addr  in  ADDR_W  first byte address; must be word aligned
word_count  in  CNT_W  number of words to load
s_valid  in  1  stream word valid
s_ready  out  1  loader can accept a word
s_data  in  32  instruction word; bits 7:0 are the lowest-address byte
mem_we  out  1  byte write strobe
mem_addr  out  ADDR_W  byte address for the write
mem_wdata  out  8  byte data for the write
cpu_hold  out  1  high from accepted start until done; drives the CPU reset
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse when the load ends, normally or on error
err  out  1  sticky error flag; cleared by the next accepted start or by reset

Behaviour:
- Reset: state goes to IDLE. s_ready, mem_we, cpu_hold, busy, done and err are all 0. mem_addr and mem_wdata are 0. Internal counters are cleared.
- Reset during a load aborts it immediately. Bytes already written stay in memory. No done pulse is produced.
- IDLE, start=1:
  - err is cleared.
  - base_addr and word_count are latched; the byte pointer is set to base_addr.
  - If base_addr[1:0] != 0, or base_addr + 4*word_count > MEM_BYTES (computed at ADDR_W+2 bits, so no wraparound): go to ERROR.
  - Else if word_count == 0: go to FINISH.
  - Else: go to ACCEPT.
- start is ignored when not in IDLE.
- ACCEPT:
  - s_ready = 1.
  - On s_valid & s_ready: latch s_data, go to WRITE with byte index 0.
  - If s_valid is low, stay in ACCEPT with no timeout.
- WRITE, four cycles:
  - s_ready = 0, mem_we = 1.
  - mem_addr = pointer + index; mem_wdata = word[8*index+7 : 8*index].
  - After index 3: the pointer advances by 4 and the remaining count decrements.
  - If the remaining count is then 0, go to FINISH; otherwise go to ACCEPT.
- Timing: a handshake in cycle N produces writes in cycles N+1..N+4, and s_ready is high again at N+5. Peak rate is one word per 5 cycles.
- FINISH, one cycle: done = 1, cpu_hold = 0, then go to IDLE.
- ERROR, one cycle: err = 1, done = 1, no writes occur, then go to IDLE. err remains high afterwards.
- cpu_hold is 1 in ACCEPT and WRITE, and 0 in FINISH, ERROR and IDLE.
- busy is 1 in every state except IDLE.
- mem_addr and mem_wdata are don't-care when mem_we = 0, but are held at their last value to reduce toggling.
- s_data is sampled only on the handshake. Changes to s_data during WRITE have no effect.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - An extra input expected_sum[31:0] is added and latched on the accepted start.
  - A running 32-bit wrapping sum of accepted words is kept and cleared on start.
  - In FINISH, if sum != expected_sum, err = 1 in the same cycle as done.
  - An extra output sum_ok equals (sum == expected_sum) and is valid from FINISH until the next start.
- Without the macro: neither port exists, and err is raised only by alignment or range errors.

Decomposition:
- Package imem_loader_pkg holds:
  - the state encoding (IDLE, ACCEPT, WRITE, FINISH, ERROR);
  - BYTES_PER_WORD = 4;
  - a localparam for the byte-index width (2).
- One sub-module, imem_word_serializer, holds the latched word and the byte index. It emits one byte per cycle on request and flags the last byte.
- The address and count bookkeeping stays in the top-level block.

Test Plan:
- Basic load: base_addr = 0, word_count = 2, words 0x00940333 and 0x800100B3 with s_valid held high. Expect byte writes (0,33), (1,03), (2,94), (3,00), (4,B3), (5,00), (6,01), (7,80). done pulses 10 cycles after the first handshake. cpu_hold is high throughout the load.
- Backpressure: base_addr = 8, word_count = 3, s_valid low for 7 cycles between words. Expect no writes while starved, and addresses 8..19 written contiguously.
- Boundary: base_addr = 124, word_count = 1 loads successfully. base_addr = 124, word_count = 2 gives err = 1 and done with zero writes. base_addr = 2 gives err = 1.
- Zero count and ignored start: word_count = 0 gives done one cycle after start, with no writes and no s_ready. A start pulse issued during WRITE has no effect.
- Reset mid-load: assert reset during the 3rd byte of the 2nd word. Expect all outputs 0 on the next cycle and no done pulse. A new start afterwards loads correctly.
- Checksum (macro defined): words 1, 2, 0xFFFFFFFF with expected_sum = 2 give sum_ok = 1 and err = 0. The same load with expected_sum = 3 gives err = 1 and sum_ok = 0.
